// File: rtl/ccr_unit_pkg.sv
// Shared definitions for the condition-code register: bit indices, jump codes
// and the ALU flag payload.
package ccr_unit_pkg;

  localparam int unsigned CCR_W = 4;

  localparam int unsigned CCR_Z = 0;
  localparam int unsigned CCR_N = 1;
  localparam int unsigned CCR_C = 2;
  localparam int unsigned CCR_V = 3;

  localparam int unsigned JC_W = 2;

  // Jump conditions; for the three flag tests the code equals the tested CCR bit index.
  typedef enum logic [JC_W-1:0] {
    JC_JZ  = 2'b00,
    JC_JN  = 2'b01,
    JC_JC  = 2'b10,
    JC_JMP = 2'b11
  } jmpCond_e;

  // ALU flags packed in CCR bit order (Z in bit 0).
  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } aluFlags_t;

endpackage : ccr_unit_pkg

// File: rtl/ccr_stack.sv
// LIFO of CCR snapshots for nested interrupts, with registered full/empty flags
// and a sticky overflow/underflow error.
module ccr_stack #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         err
);

  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptrNext;
  logic [W-1:0]  mem [DEPTH];
  logic          doPush;
  logic          doPop;
  logic          errSet;

  // Pop has priority; a push that coincides with a pop is dropped without error.
  always_comb begin
    doPop   = pop && !empty;
    doPush  = push && !pop && !full;
    errSet  = (push && !pop && full) || (pop && empty);
    ptrNext = ptr;
    if (doPop) begin
      ptrNext = ptr - PW'(1);
    end else if (doPush) begin
      ptrNext = ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      err   <= 1'b0;
    end else begin
      ptr   <= ptrNext;
      empty <= (ptrNext == '0);
      full  <= (ptrNext == PW'(DEPTH));
      err   <= err | errSet;
    end
  end

  // Storage needs no reset; contents are only read when the pointer is non-zero.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[AW'(ptr)] <= din;
    end
  end

  assign dout = mem[AW'(ptr - PW'(1))];

endmodule : ccr_stack

// File: rtl/ccr_unit.sv
// Condition-code register: masked flag latch, forwarded jump resolution with
// tested-flag clear, and interrupt save/restore through ccr_stack.
module ccr_unit
  import ccr_unit_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [CCR_W-1:0] flag_we,
  input  logic             zero_in,
  input  logic             negative_in,
  input  logic             carry_in,
  input  logic             overflow_in,
  input  logic             clrc,
  input  logic             jmp_valid,
  input  logic [JC_W-1:0]  jmp_cond,
  input  logic             int_save,
  input  logic             int_restore,
  output logic [CCR_W-1:0] ccr,
  output logic             branch_taken,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  aluFlags_t        flagIn;
  logic [CCR_W-1:0] ccrFwd;
  logic [CCR_W-1:0] ccrNext;
  logic [CCR_W-1:0] stackTop;
  jmpCond_e         cond;
  logic             stkPush;
  logic             stkPop;

  assign flagIn = '{v: overflow_in, c: carry_in, n: negative_in, z: zero_in};
  assign cond   = jmpCond_e'(jmp_cond);

  // Forwarding, jump decision and post-jump flag clear.
  always_comb begin
    ccrFwd = ccr;
    for (int i = 0; i < int'(CCR_W); i++) begin
      if (flag_we[i]) begin
        ccrFwd[i] = flagIn[i];
      end
    end
    if (clrc) begin
      ccrFwd[CCR_C] = 1'b0;
    end

    branch_taken = 1'b0;
    if (jmp_valid) begin
      case (cond)
        JC_JZ:   branch_taken = ccrFwd[CCR_Z];
        JC_JN:   branch_taken = ccrFwd[CCR_N];
        JC_JC:   branch_taken = ccrFwd[CCR_C];
        JC_JMP:  branch_taken = 1'b1;
        default: branch_taken = 1'b0;
      endcase
    end

    ccrNext = ccrFwd;
    if (branch_taken && (cond != JC_JMP)) begin
      ccrNext[jmp_cond] = 1'b0;
    end
  end

  // Restore wins over save; the stack drops a push that coincides with a pop.
  assign stkPop  = !stall && int_restore;
  assign stkPush = !stall && int_save;

  ccr_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (CCR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stkPush),
    .pop   (stkPop),
    .din   (ccrNext),
    .dout  (stackTop),
    .full  (stack_full),
    .empty (stack_empty),
    .err   (stack_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr <= '0;
    end else if (!stall) begin
      if (int_restore && !stack_empty) begin
        ccr <= stackTop;
      end else begin
        ccr <= ccrNext;
      end
    end
  end

endmodule : ccr_unit

// File: tb/tb_ccr_unit.sv
// Directed bench for ccr_unit: flag latch, forwarded jumps, clrc, nested
// interrupt stack, underflow, stall and asynchronous reset.
module tb_ccr_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic [3:0] flag_we;
  logic       zero_in;
  logic       negative_in;
  logic       carry_in;
  logic       overflow_in;
  logic       clrc;
  logic       jmp_valid;
  logic [1:0] jmp_cond;
  logic       int_save;
  logic       int_restore;
  logic [3:0] ccr;
  logic       branch_taken;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  int nChecks = 0;
  int nPass   = 0;

  ccr_unit #(.STACK_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flag_we      (flag_we),
    .zero_in      (zero_in),
    .negative_in  (negative_in),
    .carry_in     (carry_in),
    .overflow_in  (overflow_in),
    .clrc         (clrc),
    .jmp_valid    (jmp_valid),
    .jmp_cond     (jmp_cond),
    .int_save     (int_save),
    .int_restore  (int_restore),
    .ccr          (ccr),
    .branch_taken (branch_taken),
    .stack_full   (stack_full),
    .stack_empty  (stack_empty),
    .stack_err    (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) begin
      nPass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the ALU flags as {V,C,N,Z} with a write mask.
  task automatic setFlags(input logic [3:0] we, input logic [3:0] vcnz);
    flag_we     = we;
    zero_in     = vcnz[0];
    negative_in = vcnz[1];
    carry_in    = vcnz[2];
    overflow_in = vcnz[3];
  endtask

  task automatic idle();
    setFlags(4'b0000, 4'b0000);
    stall       = 1'b0;
    clrc        = 1'b0;
    jmp_valid   = 1'b0;
    jmp_cond    = 2'b00;
    int_save    = 1'b0;
    int_restore = 1'b0;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_ccr", 32'(ccr), 32'h0);
    check("rst_empty", 32'(stack_empty), 32'h1);
    check("rst_full", 32'(stack_full), 32'h0);
    check("rst_err", 32'(stack_err), 32'h0);

    // Masked flag writes
    setFlags(4'b0001, 4'b0001);
    step();
    check("we_z", 32'(ccr), 32'h1);
    setFlags(4'b1110, 4'b0110);
    step();
    check("we_nvc", 32'(ccr), 32'h7);

    // Forwarded JZ: Z set and cleared in the same cycle
    setFlags(4'b1111, 4'b0000);
    step();
    check("clear_all", 32'(ccr), 32'h0);
    setFlags(4'b0001, 4'b0001);
    jmp_valid = 1'b1;
    jmp_cond  = 2'b00;
    #1;
    check("jz_fwd_taken", 32'(branch_taken), 32'h1);
    step();
    check("jz_cleared", 32'(ccr), 32'h0);

    // JMP leaves flags alone; JN on N=0 not taken
    jmp_valid = 1'b0;
    setFlags(4'b1111, 4'b0101);
    step();
    check("set_0101", 32'(ccr), 32'h5);
    setFlags(4'b0000, 4'b0000);
    jmp_valid = 1'b1;
    jmp_cond  = 2'b11;
    #1;
    check("jmp_taken", 32'(branch_taken), 32'h1);
    step();
    check("jmp_keeps", 32'(ccr), 32'h5);
    jmp_cond = 2'b01;
    #1;
    check("jn_not_taken", 32'(branch_taken), 32'h0);
    jmp_valid = 1'b0;
    #1;
    check("no_valid", 32'(branch_taken), 32'h0);

    // clrc overrides a carry write
    setFlags(4'b0100, 4'b0100);
    clrc = 1'b1;
    step();
    check("clrc_wins", 32'(ccr), 32'h1);
    idle();
    jmp_valid = 1'b1;
    jmp_cond  = 2'b10;
    #1;
    check("jc_after_clrc", 32'(branch_taken), 32'h0);
    step();
    check("jc_keeps", 32'(ccr), 32'h1);

    // Nested interrupts
    idle();
    setFlags(4'b1111, 4'b0011);
    step();
    check("set_0011", 32'(ccr), 32'h3);
    setFlags(4'b0000, 4'b0000);
    int_save = 1'b1;
    step();
    check("save1_ccr", 32'(ccr), 32'h3);
    check("save1_empty", 32'(stack_empty), 32'h0);
    check("save1_full", 32'(stack_full), 32'h0);
    setFlags(4'b1111, 4'b1000);
    step();
    check("save2_ccr", 32'(ccr), 32'h8);
    check("save2_full", 32'(stack_full), 32'h1);
    setFlags(4'b0000, 4'b0000);
    step();
    check("save3_err", 32'(stack_err), 32'h1);
    check("save3_full", 32'(stack_full), 32'h1);
    check("save3_ccr", 32'(ccr), 32'h8);
    int_save    = 1'b0;
    int_restore = 1'b1;
    setFlags(4'b1111, 4'b0000);
    step();
    check("rti1_ccr", 32'(ccr), 32'h8);
    check("rti1_full", 32'(stack_full), 32'h0);
    setFlags(4'b1111, 4'b1111);
    step();
    check("rti2_ccr", 32'(ccr), 32'h3);
    check("rti2_empty", 32'(stack_empty), 32'h1);

    // Underflow: ccr follows flag_we, error set
    idle();
    pulseReset();
    check("rst2_err", 32'(stack_err), 32'h0);
    int_restore = 1'b1;
    setFlags(4'b0010, 4'b0010);
    step();
    check("under_ccr", 32'(ccr), 32'h2);
    check("under_err", 32'(stack_err), 32'h1);

    // Simultaneous save and restore with one entry
    idle();
    pulseReset();
    setFlags(4'b1111, 4'b0110);
    step();
    setFlags(4'b0000, 4'b0000);
    int_save = 1'b1;
    step();
    check("one_entry", 32'(stack_empty), 32'h0);
    int_save = 1'b0;
    setFlags(4'b1111, 4'b0000);
    step();
    check("pre_both", 32'(ccr), 32'h0);
    int_save    = 1'b1;
    int_restore = 1'b1;
    setFlags(4'b1111, 4'b1111);
    step();
    check("both_ccr", 32'(ccr), 32'h6);
    check("both_empty", 32'(stack_empty), 32'h1);
    check("both_err", 32'(stack_err), 32'h0);

    // Stall freezes state but branch_taken is still driven
    idle();
    stall    = 1'b1;
    int_save = 1'b1;
    setFlags(4'b1111, 4'b1111);
    clrc      = 1'b0;
    jmp_valid = 1'b1;
    jmp_cond  = 2'b00;
    #1;
    check("stall_branch", 32'(branch_taken), 32'h1);
    step();
    check("stall_ccr", 32'(ccr), 32'h6);
    check("stall_empty", 32'(stack_empty), 32'h1);

    // Asynchronous reset between edges
    idle();
    int_save = 1'b1;
    step();
    check("pre_rst_empty", 32'(stack_empty), 32'h0);
    int_save = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_ccr", 32'(ccr), 32'h0);
    check("async_empty", 32'(stack_empty), 32'h1);
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule : tb_ccr_unit
